// File: rtl/led_fader_if.sv
// Pattern-in / PWM-out signal bundle for led_fader.
interface led_fader_if;
    logic       fade_enable;
    logic [7:0] leds_in;
    logic [7:0] pin_out;
    logic       pwm_sync;
    logic       idle;

    modport master (
        output fade_enable, leds_in,
        input  pin_out, pwm_sync, idle
    );

    modport slave (
        input  fade_enable, leds_in,
        output pin_out, pwm_sync, idle
    );
endinterface

// File: rtl/led_fader.sv
// Eight-channel LED fader: ramps per-LED brightness toward the target pattern
// and drives the pins with a glitch-free PWM.
module led_fader #(
    parameter int unsigned PWM_BITS     = 4,
    parameter int unsigned STEP_DIVIDER = 48000
) (
    input  logic        clock,
    input  logic        reset_b,
    led_fader_if.slave  bus
);

    localparam int unsigned PRESC_W = (STEP_DIVIDER > 1) ? $clog2(STEP_DIVIDER) : 1;
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIVIDER - 1);

    logic [7:0]          target_q,    target_d;
    logic [PWM_BITS-1:0] pwm_count_q, pwm_count_d;
    logic [PRESC_W-1:0]  presc_q,     presc_d;
    logic [PWM_BITS-1:0] level_q [8];
    logic [PWM_BITS-1:0] level_d [8];
    logic [PWM_BITS-1:0] duty_q  [8];
    logic [PWM_BITS-1:0] duty_d  [8];
    logic [7:0]          pin_out_q,   pin_out_d;
    logic                pwm_sync_q,  pwm_sync_d;
    logic                idle_q,      idle_d;
    logic                step_tick;
    logic                all_settled;

    always_comb begin
        target_d    = bus.leds_in;
        pwm_count_d = pwm_count_q + 1'b1;
        pwm_sync_d  = (pwm_count_q == '0);
        step_tick   = bus.fade_enable && (presc_q == PRESC_LAST);

        if (!bus.fade_enable || step_tick) presc_d = '0;
        else                               presc_d = presc_q + 1'b1;

        all_settled = 1'b1;
        pin_out_d   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            level_d[i] = level_q[i];
            if (!bus.fade_enable) begin
                level_d[i] = target_q[i] ? MAX : '0;
            end else if (step_tick) begin
                if (target_q[i] && level_q[i] != MAX)
                    level_d[i] = level_q[i] + 1'b1;
                else if (!target_q[i] && level_q[i] != '0)
                    level_d[i] = level_q[i] - 1'b1;
            end

            // Duty only refreshes at the period start so a pulse is never cut mid-period.
            duty_d[i]    = (pwm_count_q == '0) ? level_q[i] : duty_q[i];
            pin_out_d[i] = (duty_q[i] == MAX) || (pwm_count_q < duty_q[i]);

            if (level_q[i] != (target_q[i] ? MAX : '0)) all_settled = 1'b0;
        end
        idle_d = all_settled;
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            target_q    <= '0;
            pwm_count_q <= '0;
            presc_q     <= '0;
            level_q     <= '{default: '0};
            duty_q      <= '{default: '0};
            pin_out_q   <= '0;
            pwm_sync_q  <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            target_q    <= target_d;
            pwm_count_q <= pwm_count_d;
            presc_q     <= presc_d;
            level_q     <= level_d;
            duty_q      <= duty_d;
            pin_out_q   <= pin_out_d;
            pwm_sync_q  <= pwm_sync_d;
            idle_q      <= idle_d;
        end
    end

    assign bus.pin_out  = pin_out_q;
    assign bus.pwm_sync = pwm_sync_q;
    assign bus.idle     = idle_q;

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream stage of the board's LED pattern generator.
- Consumes the 8-bit on/off pattern that generator produces and drives the physical LED pins with PWM.
- Each LED ramps its brightness toward its target level one step at a time, instead of switching hard.
- Gives smooth fade-in/fade-out trails for the start-up animation and any later pattern source.

Parameters:
PWM_BITS, 4, width of the PWM counter and brightness levels; MAX = 2^PWM_BITS-1
STEP_DIVIDER, 48000, clock cycles between brightness steps (must be >= 1)

Ports:
clock  input  1  system clock (12 MHz)
reset_b  input  1  asynchronous, active-low reset
fade_enable  input  1  1 = ramp brightness; 0 = levels follow target instantly
leds_in  input  8  target on/off pattern from the pattern generator
pin_out  output  8  PWM drive to LED pins, registered
pwm_sync  output  1  one-cycle pulse at the start of each PWM period
idle  output  1  1 when every level equals its endpoint (MAX if target=1, 0 if target=0)

Behaviour:
- Reset:
  - While reset_b=0, all state clears immediately, independent of clock: target, level[i], duty[i], pwm_count, prescaler, pin_out=0, pwm_sync=0, idle=1.
  - Reset asserted mid-fade discards all progress.
  - The first edge after reset_b rises behaves as cycle 0.
- Target capture: target <= leds_in every cycle (1-cycle register). No other synchronisation; leds_in comes from the same clock domain.
- PWM counter:
  - pwm_count (PWM_BITS wide) increments every cycle and wraps MAX -> 0.
  - pwm_sync <= 1 in the cycle after pwm_count==0 is seen, else 0. Period is exactly 2^PWM_BITS cycles.
- Prescaler:
  - Counts 0..STEP_DIVIDER-1, wraps to 0.
  - step_tick is asserted for the single cycle in which the prescaler equals STEP_DIVIDER-1.
  - When fade_enable=0, the prescaler is held at 0.
- Level update, per channel i, with fade_enable=1 and step_tick:
  - target[i]=1 and level<MAX -> level+1
  - target[i]=0 and level>0 -> level-1
  - Otherwise level holds. Saturating; never wraps.
  - No step_tick -> hold.
- Level update with fade_enable=0: level[i] <= target[i] ? MAX : 0 every cycle.
- Target reversal mid-ramp: the ramp continues from the current level in the new direction. No jump.
- Duty shadow: duty[i] <= level[i] only in the cycle where pwm_count==0. This keeps pulse width glitch-free within a period.
- Output: pin_out[i] <= (duty[i]==MAX) | (pwm_count < duty[i]), registered.
  - duty 0 -> always off.
  - duty MAX -> solid on, with no one-cycle gap.
  - duty k -> on for k cycles of each period, starting at the period start.
- idle: registered. Becomes 1 the cycle after all eight levels reach their endpoint; 0 otherwise.
- Worst-case response, leds_in change to pin change with fade_enable=0: 1 (target) + 1 (level) + up to 2^PWM_BITS (duty latch) + 1 (pin_out) cycles.
- All arithmetic is unsigned, PWM_BITS wide. Comparisons are unsigned.

Test Plan (PWM_BITS=2, MAX=3, STEP_DIVIDER=4 unless noted):
- Reset:
  - Run with leds_in=8'hFF until solid on, then drop reset_b asynchronously between edges.
  - Required: pin_out=0 and idle=1 immediately.
  - After release with leds_in=0: pin_out stays 0 and pwm_sync first pulses within 2 cycles.
- Fade-in:
  - leds_in=8'h01, fade_enable=1.
  - Required: level[0] steps 0->1->2->3, one step per 4 cycles.
  - Required: pin_out[0] high for 1, then 2 cycles per 4-cycle period, then solid 1; pin_out[7:1]=0 throughout.
  - Required: idle=0 until level[0]=3, then idle=1.
- Fade-out and reversal:
  - From solid 8'h01, set leds_in=0. Required: high time goes 2, then 1, then 0 cycles per period.
  - Re-assert leds_in=8'h01 when level=1. Required: level goes 1->2->3 with no jump to 0 or 3.
- Bypass:
  - fade_enable=0, leds_in=8'hA5.
  - Required: pin_out==8'hA5, solid, within 7 cycles.
  - Required: the prescaler never ticks and idle=1 once duty has latched.
- PWM framing:
  - Run 64 cycles.
  - Required: pwm_sync pulses exactly every 4 cycles, each pulse 1 cycle wide.
  - Required: mid-period level changes do not alter pin_out until the next period start.
- Saturation (PWM_BITS=4, STEP_DIVIDER=1):
  - Hold leds_in=8'hFF for 100 cycles. Required: all levels reach 15 and stay; pin_out=8'hFF solid.
  - Then hold leds_in=0 for 100 cycles. Required: all levels reach 0 with no underflow.
